// File: rtl/div3_serial_ctrl.sv
// Digit-serial divide-by-3 sequencer: one dividend nibble per cycle through a remainder/digit table.
// Optional build macro DIV3_SKIP_ZERO_EN skips leading all-zero nibbles at accept time.
module div3_serial_ctrl #(
  parameter int unsigned DATA_WIDTH = 20
) (
  input  logic                  sys_clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] divident,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [1:0]            reminder,
  output logic                  busy
);

  localparam int unsigned DIGITS = DATA_WIDTH / 4;
  localparam int unsigned CNT_W  = $clog2(DIGITS + 1);
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned TAB_N  = 64;

  if ((DATA_WIDTH % 4) != 0 || DATA_WIDTH < 8) begin : g_width_chk
    $error("div3_serial_ctrl: DATA_WIDTH must be a multiple of 4 and at least 8");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef logic [TAB_N-1:0][3:0] q_tab_t;
  typedef logic [TAB_N-1:0][1:0] r_tab_t;

  // Digit tables indexed by {remainder, nibble}; entries above 47 are never addressed.
  function automatic q_tab_t build_q_tab();
    q_tab_t t;
    for (int unsigned i = 0; i < TAB_N; i++) begin
      t[i] = 4'(i / 3);
    end
    return t;
  endfunction

  function automatic r_tab_t build_r_tab();
    r_tab_t t;
    for (int unsigned i = 0; i < TAB_N; i++) begin
      t[i] = 2'(i % 3);
    end
    return t;
  endfunction

  localparam q_tab_t Q_TAB = build_q_tab();
  localparam r_tab_t R_TAB = build_r_tab();

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [1:0]            rem_q, rem_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] quot_out_q, quot_out_d;
  logic [1:0]            rem_out_q, rem_out_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;

  logic [IDX_W-1:0]      idx;
  logic [3:0]            q_dig;
  logic [1:0]            r_dig;
  logic [DATA_WIDTH-1:0] acc_next;
  logic [DATA_WIDTH-1:0] load_sreg;
  logic [CNT_W-1:0]      load_cnt;

`ifdef DIV3_SKIP_ZERO_EN
  logic [CNT_W-1:0]      sig_cnt;
  logic [CNT_W-1:0]      skip_nib;

  // Significant-nibble count (at least 1) and MS-aligned operand for the skip-zero load.
  always_comb begin
    sig_cnt = CNT_W'(1);
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (divident[4*i +: 4] != 4'h0) begin
        sig_cnt = CNT_W'(i + 1);
      end
    end
    skip_nib  = CNT_W'(DIGITS) - sig_cnt;
    load_cnt  = sig_cnt;
    load_sreg = divident << {skip_nib, 2'b00};
  end
`else
  assign load_cnt  = CNT_W'(DIGITS);
  assign load_sreg = divident;
`endif

  assign idx      = {rem_q, sreg_q[DATA_WIDTH-1 -: 4]};
  assign q_dig    = Q_TAB[idx];
  assign r_dig    = R_TAB[idx];
  assign acc_next = {acc_q[DATA_WIDTH-5:0], q_dig};

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    quot_out_d  = quot_out_q;
    rem_out_d   = rem_out_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sreg_d     = load_sreg;
          acc_d      = '0;
          rem_d      = 2'd0;
          cnt_d      = load_cnt;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        acc_d  = acc_next;
        rem_d  = r_dig;
        sreg_d = sreg_q << 4;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          quot_out_d  = acc_next;
          rem_out_d   = r_dig;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // All state; reset discards any partial operation.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      sreg_q      <= '0;
      acc_q       <= '0;
      rem_q       <= 2'd0;
      cnt_q       <= '0;
      quot_out_q  <= '0;
      rem_out_q   <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      quot_out_q  <= quot_out_d;
      rem_out_q   <= rem_out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign quotient  = quot_out_q;
  assign reminder  = rem_out_q;

endmodule

// File: tb/tb_div3_serial_ctrl.sv
// Directed and randomised checks of div3_serial_ctrl; follows DIV3_SKIP_ZERO_EN when defined.
module tb_div3_serial_ctrl;

  logic        sys_clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] divident;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] quotient;
  logic [1:0]  reminder;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  div3_serial_ctrl #(.DATA_WIDTH(20)) dut (
    .sys_clock (sys_clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .divident  (divident),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .reminder  (reminder),
    .busy      (busy)
  );

  initial sys_clock = 1'b0;
  always #5 sys_clock = ~sys_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected RUN length for an operand.
  function automatic int run_len(input logic [19:0] x);
`ifdef DIV3_SKIP_ZERO_EN
    int n;
    n = 1;
    for (int i = 0; i < 5; i++) begin
      if (x[4*i +: 4] != 4'h0) n = i + 1;
    end
    return n;
`else
    return 5;
`endif
  endfunction

  // Starts and ends on a falling edge; offers x, waits for result, holds it 'hold' cycles, accepts.
  task automatic run_op(input string tag, input logic [19:0] x, input logic [19:0] eq,
                        input logic [1:0] er, input int elat, input int hold);
    int lat;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    divident = x;
    @(negedge sys_clock);
    in_valid = 1'b0;
    divident = 20'h0;
    lat = 0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    while (!out_valid && lat < 20) begin
      @(negedge sys_clock);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    chk({tag, "_quotient"}, 32'(quotient), 32'(eq));
    chk({tag, "_reminder"}, 32'(reminder), 32'(er));
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge sys_clock);
      chk({tag, "_hold_q"}, 32'(quotient), 32'(eq));
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge sys_clock);
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [19:0] x;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    divident  = 20'h0;
    repeat (2) @(negedge sys_clock);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_reminder", 32'(reminder), 32'd0);
    reset_n = 1'b1;
    @(negedge sys_clock);

    // Directed operands with hand-computed results.
`ifdef DIV3_SKIP_ZERO_EN
    run_op("d100", 20'd100, 20'd33, 2'd1, 2, 0);
    run_op("dffff", 20'hFFFFF, 20'h55555, 2'd0, 5, 0);
    run_op("dzero", 20'd0, 20'd0, 2'd0, 1, 0);
    run_op("d5", 20'h00005, 20'd1, 2'd2, 1, 0);
    run_op("d10000", 20'h10000, 20'd21845, 2'd1, 5, 0);
`else
    run_op("d100", 20'd100, 20'd33, 2'd1, 5, 0);
    run_op("dffff", 20'hFFFFF, 20'h55555, 2'd0, 5, 0);
    run_op("dzero", 20'd0, 20'd0, 2'd0, 5, 0);
    run_op("d5", 20'h00005, 20'd1, 2'd2, 5, 0);
    run_op("d10000", 20'h10000, 20'd21845, 2'd1, 5, 0);
`endif
    run_op("d8", 20'd8, 20'd2, 2'd2, run_len(20'd8), 0);

    // Backpressure: result held 10 cycles while a new offer is ignored.
    in_valid = 1'b1;
    divident = 20'd1000;
    @(negedge sys_clock);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge sys_clock);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_quotient0", 32'(quotient), 32'd333);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      divident = 20'd9;
      @(negedge sys_clock);
      chk("bp_hold_q", 32'(quotient), 32'd333);
      chk("bp_hold_r", 32'(reminder), 32'd1);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge sys_clock);
    out_ready = 1'b0;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_release_busy", 32'(busy), 32'd0);
    chk("bp_release_q", 32'(quotient), 32'd333);

    // Reset during RUN clears everything immediately.
    in_valid = 1'b1;
    divident = 20'd12345;
    @(negedge sys_clock);
    in_valid = 1'b0;
    @(negedge sys_clock);
    @(negedge sys_clock);
    chk("mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_q", 32'(quotient), 32'd0);
    chk("mid_rst_r", 32'(reminder), 32'd0);
    @(negedge sys_clock);
    reset_n = 1'b1;
    @(negedge sys_clock);
    run_op("post_rst7", 20'd7, 20'd2, 2'd1, run_len(20'd7), 0);

    // Randomised operands, idle gaps and consumer stalls against a reference divide.
    for (int n = 0; n < 2000; n++) begin
      x = 20'($urandom);
      if (n % 7 == 0) x = x & 20'h000FF;
      repeat ($urandom_range(0, 2)) @(negedge sys_clock);
      run_op("rand", x, x / 20'd3, 2'(x % 20'd3), run_len(x), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
